// File: rtl/port_xfer_ctrl_if.sv
// Request/response handshake plus pad-side signals of the bidirectional port engine.
// The master side is the requesting FSM and pad model; the slave side is port_xfer_ctrl.
interface port_xfer_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] port_in;
  logic [WIDTH-1:0] port_out;
  logic             port_oe;
  logic             port_dir;
  logic             busy;

  modport master (
    output req_valid, req_write, req_data, port_in,
    input  req_ready, rsp_valid, rsp_data, port_out, port_oe, port_dir, busy
  );

  modport slave (
    input  req_valid, req_write, req_data, port_in,
    output req_ready, rsp_valid, rsp_data, port_out, port_oe, port_dir, busy
  );
endinterface

// File: rtl/port_xfer_ctrl.sv
// Single-word transfer engine for a bidirectional pad bundle: sequences buffer
// direction and local output enable with a dead-time turnaround, and synchronises reads.
module port_xfer_ctrl #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int TURN_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int RELEASE_IDLE = 0
) (
  input  logic           clk,
  input  logic           reset,
  port_xfer_ctrl_if.slave bus
);

  localparam int MAX_A   = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
  localparam int MAX_B   = (MAX_A > SYNC_STAGES + 1) ? MAX_A : SYNC_STAGES + 1;
  localparam int MAX_CNT = (MAX_B > RELEASE_IDLE) ? MAX_B : RELEASE_IDLE;
  localparam int CW      = $clog2(MAX_CNT + 1) + 1;
  localparam int REL_LAST = (RELEASE_IDLE == 0) ? 0 : RELEASE_IDLE - 1;

  typedef enum logic [2:0] {
    IDLE,
    TURN_OUT,
    DRIVE,
    TURN_IN,
    SAMPLE
  } state_e;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [CW-1:0]                      idle_cnt_q, idle_cnt_d;
  logic                               release_q, release_d;
  logic [WIDTH-1:0]                   data_q, data_d;
  logic                               port_dir_q, port_dir_d;
  logic                               port_oe_q, port_oe_d;
  logic [WIDTH-1:0]                   port_out_q, port_out_d;
  logic                               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]                   rsp_data_q, rsp_data_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q, sync_d;
  logic                               accept;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_cnt_d  = '0;
    release_d   = release_q;
    data_d      = data_q;
    port_dir_d  = port_dir_q;
    port_oe_d   = port_oe_q;
    port_out_d  = port_out_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.port_in};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          data_d = bus.req_data;
          if (bus.req_write) begin
            if (port_dir_q) begin
              state_d    = DRIVE;
              port_out_d = bus.req_data;
              port_oe_d  = 1'b1;
            end else begin
              state_d    = TURN_OUT;
              port_dir_d = 1'b1;
            end
          end else if (port_dir_q) begin
            state_d   = TURN_IN;
            port_oe_d = 1'b0;
            release_d = 1'b0;
          end else begin
            state_d = SAMPLE;
          end
        end else if ((RELEASE_IDLE != 0) && port_dir_q) begin
          // An accept on the terminal idle cycle takes the branch above instead.
          if (idle_cnt_q == CW'(REL_LAST)) begin
            state_d   = TURN_IN;
            port_oe_d = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      TURN_OUT: begin
        if (cnt_q == CW'(TURN_CYCLES - 1)) begin
          state_d    = DRIVE;
          port_out_d = data_q;
          port_oe_d  = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN_IN: begin
        if (cnt_q == CW'(TURN_CYCLES - 1)) begin
          port_dir_d = 1'b0;
          cnt_d      = '0;
          release_d  = 1'b0;
          state_d    = release_q ? IDLE : SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (cnt_q == CW'(SYNC_STAGES)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = sync_q[SYNC_STAGES-1];
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idle_cnt_q  <= '0;
      release_q   <= 1'b0;
      data_q      <= '0;
      port_dir_q  <= 1'b0;
      port_oe_q   <= 1'b0;
      port_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      release_q   <= release_d;
      data_q      <= data_d;
      port_dir_q  <= port_dir_d;
      port_oe_q   <= port_oe_d;
      port_out_q  <= port_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sync_q      <= sync_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.port_dir  = port_dir_q;
  assign bus.port_oe   = port_oe_q;
  assign bus.port_out  = port_out_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // The pads and the external buffer must never drive against each other.
  oe_implies_dir: assert property (@(posedge clk) disable iff (reset) port_oe_q |-> port_dir_q);

endmodule

// File: doc/port_xfer_ctrl.md
Name: port_xfer_ctrl

Overview:
Parametrised bidirectional-port transfer engine; successor to the plain direction-select port bundle.
- Accepts single-word write/read requests over a valid/ready handshake.
- Sequences the external tri-state buffer direction and the local output enable with a programmable turnaround so the two drivers never overlap.
- Synchronises inbound port data before returning it, and optionally releases the bus after an idle period.
- Sits between cart/link protocol FSMs and the top-level pad buffers.

Parameters:
WIDTH, 8, port data width (>=1)
SYNC_STAGES, 2, input synchroniser depth (>=2)
TURN_CYCLES, 2, dead cycles inserted on every direction change (>=1)
HOLD_CYCLES, 1, cycles each write word is held before the next request is accepted (>=1)
RELEASE_IDLE, 0, idle cycles in TO_PORT before auto-return to FROM_PORT; 0 = never (0..65535)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready at clk rising edge
req_write  in  1  1 = write word to port, 0 = read word from port
req_data  in  WIDTH  write data
rsp_valid  out  1  one-cycle pulse: read data valid; no backpressure
rsp_data  out  WIDTH  read data, held until next read completes
port_in  in  WIDTH  raw pad input, asynchronous
port_out  out  WIDTH  pad output data
port_oe  out  1  local output enable; pads driven only when 1
port_dir  out  1  external buffer direction: 0 FROM_PORT, 1 TO_PORT
busy  out  1  state != IDLE

Behaviour:
- Reset values: port_dir=0, port_oe=0, port_out=0, req_ready=1, rsp_valid=0, rsp_data=0, sync chain=0, all counters=0, state=IDLE.
- Synchroniser: SYNC_STAGES flops on port_in, free-running, cleared by reset.
- States: IDLE, TURN_OUT, DRIVE, TURN_IN, SAMPLE.
- req_ready=1 only in IDLE. Requests are accepted only in IDLE.
- Write accepted with port_dir=1: go to DRIVE. port_out<=req_data and port_oe<=1 on the accept edge.
- Write accepted with port_dir=0: go to TURN_OUT. port_dir<=1 on the accept edge; port_oe stays 0. Stay TURN_CYCLES cycles, then DRIVE with port_out<=data and port_oe<=1.
- Direction-change ordering:
  - Going to port: dir flips first, oe rises after the turnaround.
  - Going from port: oe falls first, dir flips after the turnaround.
- DRIVE lasts HOLD_CYCLES cycles, then IDLE. port_oe stays 1 and port_out holds the last word while parked in IDLE.
- Read accepted with port_dir=0: go to SAMPLE.
- Read accepted with port_dir=1: go to TURN_IN. port_oe<=0 on the accept edge; port_dir stays 1 for TURN_CYCLES cycles; port_dir<=0 on the edge leaving TURN_IN; then SAMPLE.
- SAMPLE lasts SYNC_STAGES+1 cycles. On its final edge: rsp_data<=synchroniser output, rsp_valid<=1 for one cycle, state<=IDLE. Bus caller guarantees port_in is stable from SAMPLE entry.
- Auto-release (RELEASE_IDLE>0): in IDLE with port_dir=1, an idle counter increments each cycle with no accept.
  - When it reaches RELEASE_IDLE, perform the TURN_IN sequence (oe low, wait, dir low), then return to IDLE with no rsp_valid.
  - req_ready=0 during the release.
  - Any accept clears the counter.
- Simultaneous accept and counter terminal value: the accept wins.
- req_data and req_write are sampled only on the accept edge; later changes are ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any in-flight word is discarded; no rsp_valid is emitted.
- Invariant, checked by assertion: port_oe=1 implies port_dir=1.
- Counters are sized $clog2 of the max parameter + 1. No wrap is reachable.

Test Plan:
- Reset, then write 8'hA5 (port_dir=0, TURN=2, HOLD=1): accept edge0 -> port_dir=1 after edge0, port_oe=1 & port_out=A5 after edge2, req_ready=1 after edge3.
- Back-to-back writes A5 then 3C while in TO_PORT: no turnaround; port_out=3C one cycle after the second accept; port_dir/port_oe never drop.
- Read after a write, port_in=8'h5A: port_oe=0 after the accept edge, port_dir=0 two edges later, rsp_valid pulses exactly once with rsp_data=5A, SYNC_STAGES+1 edges after the dir flip.
- Read from FROM_PORT with SYNC_STAGES=3: rsp_valid high after 4 edges; rsp_data=port_in value; port_dir/port_oe stay 0.
- RELEASE_IDLE=4: write, then idle -> port_oe=0 after 4 idle cycles, port_dir=0 TURN_CYCLES later, no rsp_valid. Repeat with an accept on the terminal cycle -> write proceeds, no release.
- Assert reset during TURN_OUT and during SAMPLE: all outputs return to reset values the same cycle; no rsp_valid after deassert; the next request completes normally.
